// File: rtl/nibble_serial_skip_adder.sv
// Serial WIDTH-bit adder: one 4-bit carry-skip slice per cycle, LSB nibble first; ADDER_OVF_EN adds signed overflow.
// Latency: WIDTH/4 cycles from operand accept to out_valid; minimum period WIDTH/4+2.
// Backpressure: in_ready only in IDLE; result held frozen in DONE until out_ready.
module nibble_serial_skip_adder #(
    parameter int WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               a,
    input  logic [WIDTH-1:0]               b,
    input  logic                           cin,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               sum,
    output logic                           cout,
    output logic [$clog2(WIDTH/4+1)-1:0]   skip_cnt
`ifdef ADDER_OVF_EN
    ,
    output logic                           overflow
`endif
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = $clog2(N + 1);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [KW-1:0]   k;
    logic            carry_q;

    logic [3:0]      nib_a, nib_b, prop;
    logic [4:0]      ripple;
    logic            skip, carry_nxt, last;

    assign in_ready = (state == IDLE);

    // Current slice: ripple result plus the carry-skip bypass decision.
    always_comb begin
        nib_a     = a_q[{k, 2'b00} +: 4];
        nib_b     = b_q[{k, 2'b00} +: 4];
        prop      = nib_a ^ nib_b;
        ripple    = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
        skip      = &prop;
        carry_nxt = skip ? carry_q : ripple[4];
        last      = (k == K_LAST);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            k         <= '0;
            carry_q   <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            skip_cnt  <= '0;
            out_valid <= 1'b0;
`ifdef ADDER_OVF_EN
            overflow  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry_q  <= cin;
                        sum      <= '0;
                        skip_cnt <= '0;
                        k        <= '0;
                    end
                end
                RUN: begin
                    sum[{k, 2'b00} +: 4] <= ripple[3:0];
                    carry_q              <= carry_nxt;
                    if (skip) skip_cnt <= skip_cnt + SW'(1);
                    if (last) begin
                        cout      <= carry_nxt;
                        out_valid <= 1'b1;
`ifdef ADDER_OVF_EN
                        // ripple[3] is the sum MSB being written this edge
                        overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                     (ripple[3] != a_q[WIDTH-1]);
`endif
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // A bypassed slice has all propagate bits set, so its ripple carry must equal its carry-in.
    a_skip_matches_ripple: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state == RUN) |-> (carry_nxt == ripple[4])
    );

endmodule
